// File: rtl/instr_mem_server.sv
// Instruction memory server: 256x8 byte store that returns a 10-byte window per fetch.
// Optional bounds checking is enabled by defining IMEM_BOUNDS_CHECK_EN.
module instr_mem_server (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [63:0] fetch_pc,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [0:79] fetch_instr,
    output logic        fetch_err,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_drop
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mem [256];
    logic [7:0]  pc;
    logic [3:0]  cnt;
    logic [7:0]  rd_byte;
    logic        accept;
    logic        out_of_range;
    logic        err_q;

    assign accept = fetch_req && (state == IDLE);

`ifdef IMEM_BOUNDS_CHECK_EN
    assign out_of_range = (|fetch_pc[63:8]) || (fetch_pc[7:0] > 8'd246);
`else
    logic unused_pc_hi;
    assign unused_pc_hi = ^fetch_pc[63:8];
    assign out_of_range = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = out_of_range ? RESP : READ;
            READ: if (cnt == 4'd9) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writes only land while idle, so an in-flight window always sees a stable array.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_data;
    end

    assign rd_byte = mem[pc + {4'b0000, cnt}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            cnt         <= '0;
            fetch_instr <= '0;
            err_q       <= 1'b0;
            wr_drop     <= 1'b0;
        end else begin
            wr_drop <= wr_en && (state != IDLE);
            if (accept) begin
                pc          <= fetch_pc[7:0];
                cnt         <= '0;
                fetch_instr <= '0;
                err_q       <= out_of_range;
            end else if (state == READ) begin
                fetch_instr[{cnt, 3'b000} +: 8] <= rd_byte;
                cnt                             <= cnt + 4'd1;
            end
        end
    end

    assign fetch_ready = (state == IDLE);
    assign fetch_valid = (state == RESP);
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Directed self-checking bench for instr_mem_server (default or IMEM_BOUNDS_CHECK_EN build).
module tb_instr_mem_server;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [63:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [0:79] fetch_instr;
    logic        fetch_err;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_drop;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    instr_mem_server dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_err   (fetch_err),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_drop     (wr_drop)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Issues one request (optionally with a same-edge IDLE write) and waits, bounded, for the response.
    task automatic do_fetch(input logic [63:0] pc, input bit with_wr, input logic [7:0] a,
                            input logic [7:0] d, output logic [0:79] instr, output logic err,
                            output int unsigned lat, output int unsigned low);
        @(negedge clk);
        fetch_req = 1'b1; fetch_pc = pc;
        if (with_wr) begin wr_en = 1'b1; wr_addr = a; wr_data = d; end
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0; wr_en = 1'b0;
        lat = 0; low = 0;
        while (!fetch_valid && lat < 20) begin
            if (!fetch_ready) low++;
            @(negedge clk);
            lat++;
        end
        if (!fetch_ready) low++;
        instr = fetch_instr;
        err   = fetch_err;
        @(negedge clk);
        check("valid_pulse_1cyc", {79'd0, fetch_valid}, 80'd0);
        check("instr_held", fetch_instr, instr);
    endtask

    logic [0:79]  instr;
    logic         err;
    int unsigned  lat, low, nval;

    initial begin
        rst = 1'b1;
        #12;
        check("rst_ready",  {79'd0, fetch_ready}, 80'd1);
        check("rst_valid",  {79'd0, fetch_valid}, 80'd0);
        check("rst_err",    {79'd0, fetch_err},   80'd0);
        check("rst_wr_drop",{79'd0, wr_drop},     80'd0);
        check("rst_instr",  fetch_instr,          80'd0);
        @(negedge clk);
        rst = 1'b0;

        wr_byte(8'd0, 8'h30); wr_byte(8'd1, 8'hF6);
        for (int i = 2; i < 9; i++) wr_byte(8'(i), 8'h00);
        wr_byte(8'd9, 8'hFF);
        wr_byte(8'd20, 8'h20); wr_byte(8'd21, 8'h76);
        for (int i = 0; i < 4; i++) wr_byte(8'(246 + i), 8'(8'hB6 + i));
        for (int i = 0; i < 6; i++) wr_byte(8'(250 + i), 8'(8'hA0 + i));

        do_fetch(64'd0, 1'b0, 8'd0, 8'd0, instr, err, lat, low);
        check("pc0_instr", instr, 80'h30F600000000000000FF);
        check("pc0_err",   {79'd0, err}, 80'd0);
        check("pc0_lat",   80'(lat), 80'd10);

        do_fetch(64'd20, 1'b0, 8'd0, 8'd0, instr, err, lat, low);
        check("pc20_hi16",    {64'd0, instr[0:15]}, 80'h2076);
        check("pc20_ready_lo", 80'(low), 80'd11);

        do_fetch(64'd246, 1'b0, 8'd0, 8'd0, instr, err, lat, low);
        check("pc246_instr", instr, 80'hB6B7B8B9A0A1A2A3A4A5);
        check("pc246_err",   {79'd0, err}, 80'd0);

        do_fetch(64'd250, 1'b0, 8'd0, 8'd0, instr, err, lat, low);
`ifdef IMEM_BOUNDS_CHECK_EN
        check("pc250_instr", instr, 80'd0);
        check("pc250_err",   {79'd0, err}, 80'd1);
        check("pc250_lat",   80'(lat), 80'd0);
        do_fetch(64'h100, 1'b0, 8'd0, 8'd0, instr, err, lat, low);
        check("pc_hi_err",   {79'd0, err}, 80'd1);
`else
        check("pc250_instr", instr, 80'hA0A1A2A3A4A530F60000);
        check("pc250_err",   {79'd0, err}, 80'd0);
        check("pc250_lat",   80'(lat), 80'd10);
`endif

        // Write during READ must be dropped.
        @(negedge clk);
        fetch_req = 1'b1; fetch_pc = 64'd20;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'hAB;
        @(negedge clk);
        wr_en = 1'b0;
        check("wr_drop_pulse", {79'd0, wr_drop}, 80'd1);
        @(negedge clk);
        check("wr_drop_clear", {79'd0, wr_drop}, 80'd0);
        lat = 0;
        while (!fetch_valid && lat < 20) begin @(negedge clk); lat++; end
        check("drop_fetch_done", {79'd0, fetch_valid}, 80'd1);

        do_fetch(64'd0, 1'b0, 8'd0, 8'd0, instr, err, lat, low);
        check("mem5_unchanged", instr, 80'h30F600000000000000FF);

        // Reset in the middle of a window aborts it.
        @(negedge clk);
        fetch_req = 1'b1; fetch_pc = 64'd20;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_instr", fetch_instr, 80'd0);
        check("abort_valid", {79'd0, fetch_valid}, 80'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", {79'd0, fetch_ready}, 80'd1);
        nval = 0;
        repeat (15) begin @(negedge clk); if (fetch_valid) nval++; end
        check("abort_no_valid", 80'(nval), 80'd0);

        do_fetch(64'd0, 1'b0, 8'd0, 8'd0, instr, err, lat, low);
        check("post_rst_pc0", instr, 80'h30F600000000000000FF);

        do_fetch(64'd0, 1'b1, 8'd5, 8'hAB, instr, err, lat, low);
        check("idle_wr_same_edge", instr, 80'h30F6000000AB000000FF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
